// File: rtl/sar_adc_wr.sv
// sar_adc_wr
// Behavioural successive-approximation ADC. It digitises the filtered analog
// signal from the upstream low-pass filter into an NBITS unsigned code. A
// controller paces conversions with a start/busy/valid handshake.
//
// Ports:
//   clk    in   conversion clock, rising-edge active
//   rst_n  in   asynchronous active-low reset
//   vin    in   analog input (real), sampled on the edge that accepts start
//   start  in   conversion request; ignored while busy
//   busy   out  high while a conversion is in progress
//   valid  out  one-cycle pulse when dout/ovr are updated
//   dout   out  last completed conversion code (held between conversions)
//   ovr    out  held sample was strictly outside [VREFN, VREFP]
//   vdac   out  current internal DAC trial voltage (debug)
module sar_adc_wr #(
  parameter int  NBITS = 8,
  parameter real VREFP = 1.0,
  parameter real VREFN = 0.0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  real              vin,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [NBITS-1:0] dout,
  output logic             ovr,
  output real              vdac
);

  localparam int               IW       = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam real              LSB      = (VREFP - VREFN) / real'(2 ** NBITS);
  localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [IW-1:0]    TOP_IDX  = IW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_reg, state_next;
  real              vh_reg, vh_next;
  logic [NBITS-1:0] trial_reg, trial_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [NBITS-1:0] dout_reg, dout_next;
  logic             ovr_reg, ovr_next;
  logic             valid_reg, valid_next;
  logic             busy_reg, busy_next;

  // Per-edge bit decision and the code with the current bit resolved.
  logic             keep;
  logic [NBITS-1:0] decided;
  real              vin_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      vh_reg    <= 0.0;
      trial_reg <= '0;
      idx_reg   <= '0;
      dout_reg  <= '0;
      ovr_reg   <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      vh_reg    <= vh_next;
      trial_reg <= trial_next;
      idx_reg   <= idx_next;
      dout_reg  <= dout_next;
      ovr_reg   <= ovr_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vh_next    = vh_reg;
    trial_next = trial_reg;
    idx_next   = idx_reg;
    dout_next  = dout_reg;
    ovr_next   = ovr_reg;
    valid_next = 1'b0;
    busy_next  = busy_reg;

    // A NaN input (also how an undriven analog net shows up) samples as 0 V.
    vin_s = (vin != vin) ? 0.0 : vin;

    // Equality keeps the bit, so a sample exactly on a code boundary
    // resolves upward (and VH == VREFP yields all-ones).
    keep    = (vh_reg >= VREFN + real'(trial_reg) * LSB);
    decided = trial_reg;
    decided[idx_reg] = keep;

    case (state_reg)
      IDLE, DONE: begin
        // DONE behaves like IDLE for acceptance, which gives back-to-back
        // conversions every NBITS+1 cycles when start is held.
        if (start) begin
          vh_next    = vin_s;
          trial_next = MSB_ONLY;
          idx_next   = TOP_IDX;
          busy_next  = 1'b1;
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      CONV: begin
        if (idx_reg != '0) begin
          trial_next = decided;
          trial_next[idx_reg - 1'b1] = 1'b1;
          idx_next   = idx_reg - 1'b1;
        end else begin
          trial_next = decided;
          dout_next  = decided;
          ovr_next   = (vh_reg > VREFP) || (vh_reg < VREFN);
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy  = busy_reg;
  assign valid = valid_reg;
  assign dout  = dout_reg;
  assign ovr   = ovr_reg;

  // The DAC follows the trial code; it holds the final code once done.
  always_comb begin
    vdac = VREFN + real'(trial_reg) * LSB;
  end

endmodule

// File: tb/tb_sar_adc_wr.sv
module tb_sar_adc_wr;

  logic       clk;
  logic       rst_n;
  real        vin;
  logic       start;
  logic       busy;
  logic       valid;
  logic [7:0] dout;
  logic       ovr;
  real        vdac;

  int n_checks = 0;
  int n_fail   = 0;

  sar_adc_wr #(.NBITS(8), .VREFP(1.0), .VREFN(0.0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vin   (vin),
    .start (start),
    .busy  (busy),
    .valid (valid),
    .dout  (dout),
    .ovr   (ovr),
    .vdac  (vdac)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    real        vin;
    logic [7:0] dout;
    logic       ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_real(input string name, input real got, input real exp);
    real d;
    n_checks++;
    d = got - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9) begin
      n_fail++;
      $display("FAIL %s: got %f expected %f", name, got, exp);
    end
  endtask

  // Start a conversion, then walk the 8 conversion edges checking the
  // handshake timing and, on the last edge, the result.
  task automatic convert(input real v, input logic [7:0] exp_dout, input logic exp_ovr);
    logic busy_ok;
    logic valid_early;
    vin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 16'(busy), 16'd1);
    check_real("vdac_msb_trial", vdac, 0.5);
    busy_ok     = 1'b1;
    valid_early = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c < 8) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (valid !== 1'b0) valid_early = 1'b1;
      end
    end
    check("busy_held_8", 16'(busy_ok), 16'd1);
    check("no_early_valid", 16'(valid_early), 16'd0);
    check("valid_at_k8", 16'(valid), 16'd1);
    check("busy_low_at_k8", 16'(busy), 16'd0);
    check("dout", 16'(dout), 16'(exp_dout));
    check("ovr", 16'(ovr), 16'(exp_ovr));
    check_real("vdac_final", vdac, real'(exp_dout) / 256.0);
    $display("conv vin=%f dout=%0d ovr=%0d (exp %0d/%0d)", v, dout, ovr, exp_dout, exp_ovr);
    tick();
    check("valid_low_k9", 16'(valid), 16'd0);
    check("dout_hold", 16'(dout), 16'(exp_dout));
  endtask

  initial begin
    int nvalid;
    vecs[0] = '{0.5,    8'd128, 1'b0};
    vecs[1] = '{0.2,    8'd51,  1'b0};
    vecs[2] = '{0.999,  8'd255, 1'b0};
    vecs[3] = '{0.25,   8'd64,  1'b0};
    vecs[4] = '{1.2,    8'd255, 1'b1};
    vecs[5] = '{-0.1,   8'd0,   1'b1};
    vecs[6] = '{1.0,    8'd255, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    vin   = 0.0;
    #12;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_dout", 16'(dout), 16'd0);
    check("rst_ovr", 16'(ovr), 16'd0);
    check_real("rst_vdac", vdac, 0.0);
    rst_n = 1'b1;
    tick();

    // Table-driven single conversions.
    foreach (vecs[i]) begin
      convert(vecs[i].vin, vecs[i].dout, vecs[i].ovr);
      tick();
    end

    // Input stepped and start re-pulsed mid-conversion: result follows the
    // held sample and no second conversion is queued.
    vin   = 0.3;
    start = 1'b1;
    tick();
    start = 1'b0;
    nvalid = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        vin   = 0.9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (valid) nvalid++;
      if (c == 8) begin
        check("mid_valid_k8", 16'(valid), 16'd1);
        check("mid_dout", 16'(dout), 16'd76);
      end
    end
    check("mid_single_valid", 16'(nvalid), 16'd1);
    $display("mid-conversion step dout=%0d valids=%0d", dout, nvalid);

    // Start held high: a result every 9 cycles.
    vin   = 0.75;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 36; c++) begin
      tick();
      check("b2b_valid", 16'(valid), 16'((c >= 8) && ((c - 8) % 9 == 0)));
      if (valid) begin
        check("b2b_dout", 16'(dout), 16'd192);
        $display("back-to-back cycle=%0d dout=%0d", c, dout);
      end
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) tick();

    // Reset during conversion aborts it and clears the outputs at once.
    vin   = 0.2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_valid", 16'(valid), 16'd0);
    check("abort_dout", 16'(dout), 16'd0);
    check("abort_ovr", 16'(ovr), 16'd0);
    check_real("abort_vdac", vdac, 0.0);
    $display("reset mid-conversion busy=%0d dout=%0d", busy, dout);
    tick();
    rst_n = 1'b1;
    tick();
    convert(0.5, 8'd128, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sar_adc_wr.md
Name: sar_adc_wr

Overview:
Behavioural successive-approximation ADC model. It sits directly downstream of the first-order wreal low-pass filter and digitises the filtered analog output into an NBITS code. A start/busy/valid handshake lets a digital controller pace conversions. The model is used in mixed-signal top-level simulation in place of the transistor-level ADC.

Parameters:
NBITS, 8, output code width (2..16)
VREFP, 1.0, upper reference voltage [V], real
VREFN, 0.0, lower reference voltage [V], real; VREFP > VREFN required

Ports:
CLK  input  1  conversion clock, rising-edge active
RST_N  input  1  asynchronous active-low reset
VIN  input  wreal  analog input (LPF output)
START  input  1  conversion request, sampled on rising CLK
BUSY  output  1  high while a conversion is in progress
VALID  output  1  one-cycle pulse when DOUT is updated
DOUT  output  NBITS  last completed conversion code, unsigned
OVR  output  1  input out of range for the last completed conversion
VDAC  output  wreal  current internal DAC trial voltage (debug)

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; BUSY=0, VALID=0, DOUT=0, OVR=0, VDAC=VREFN; held sample=0.0; trial code=0.
- Reset asserted mid-conversion aborts it immediately. DOUT/OVR go to 0. After release, the next accepted START begins a fresh conversion.
- LSB = (VREFP-VREFN)/2^NBITS.
- States: IDLE, CONV, DONE.
- IDLE: on a CLK edge with START=1:
  - Latch VH=VIN (track/hold).
  - Set trial code to MSB only; VDAC=VREFN+trial*LSB.
  - BUSY=1, bit index i=NBITS-1, go to CONV.
- CONV: each CLK edge decides bit i.
  - Keep bit i if VH >= VREFN+trial*LSB (equality keeps the bit); otherwise clear it.
  - Then set bit i-1 as the next trial and update VDAC.
  - After bit 0 is decided, go to DONE.
  - NBITS edges are spent in CONV.
- DONE entry edge (same edge bit 0 is decided):
  - DOUT=final code; VALID=1; BUSY=0.
  - OVR=1 if VH>VREFP or VH<VREFN (strict); else 0.
- DONE, next edge: VALID=0.
  - If START=1, accept a new conversion exactly as from IDLE (back-to-back); otherwise go to IDLE.
- Latency: START accepted at edge k -> VALID high and DOUT updated at edge k+NBITS, low at k+NBITS+1. Back-to-back throughput is one conversion per NBITS+1 cycles.
- START while BUSY=1 is ignored, with no queuing.
- VIN changes after the sampling edge do not affect the result.
- Clamping: VH>=VREFP -> code 2^NBITS-1; VH<VREFN -> code 0. The bit search yields these naturally; the equality VH==VREFP gives all-ones with OVR=0.
- DOUT holds its value between conversions. VDAC holds its last trial value in IDLE/DONE.
- VIN that is undriven or evaluates to NaN is treated as 0.0 at sampling.

Test Plan:
- NBITS=8, VREF 0..1: VIN=0.5, START pulse -> BUSY high 8 cycles; VALID pulse at k+8; DOUT=128, OVR=0.
- VIN=0.2 -> DOUT=51. VIN=0.999 -> DOUT=255. VIN exactly 0.25 -> DOUT=64 (equality keeps bit).
- VIN=1.2 -> DOUT=255, OVR=1. VIN=-0.1 -> DOUT=0, OVR=1.
- VIN=0.3 sampled, then stepped to 0.9 during CONV, START re-pulsed mid-conversion -> DOUT=76, no extra conversion, VALID single pulse.
- START held high continuously with VIN=0.75 -> VALID every 9 cycles, DOUT=192 each time.
- RST_N pulled low at conversion cycle 4 -> BUSY/VALID/DOUT/OVR=0 immediately. After release, a new START with VIN=0.5 -> DOUT=128 at k+8.
